bcd_string_seq: RTL and testbench
=================================

Name: bcd_string_seq

Overview:
- Multi-cycle sequencer for the NEC packed-BCD string instructions ADD4S, SUB4S and CMP4S.
- Walks CL digits (two per byte) of a source string at DS:SI and a destination string at ES:DI, low byte first.
- Each byte pair goes through a dedicated ALU in two passes: ADDC/SUBC, then ADJ4A/ADJ4S.
- Writes the adjusted byte back to the destination (except CMP4S). Sits beside the execute unit; the core hands over CL/SI/DI and waits on done.

Parameters:
SETUP_CYCLES, 7, fixed start overhead in cycles (used only with the timing feature)
BYTE_CYCLES, 19, total cycles per byte (used only with the timing feature)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; state advances only when ce=1
start  in  1  one-cycle request to begin an operation
op  in  bcd_op_e (2)  BCD_ADD4S / BCD_SUB4S / BCD_CMP4S
count  in  8  CL: digit count
src_addr  in  16  SI, offset in the DS segment
dst_addr  in  16  DI, offset in the ES segment
flags_in  in  flags_t  current PSW flags
busy  out  1  high from the start cycle until done
done  out  1  one-cycle pulse when the operation completes
flags_out  out  flags_t  flags_in with CY and Z replaced; valid when done=1
mem_req  out  1  memory request
mem_wr  out  1  1 = write, 0 = read
mem_seg_es  out  1  1 = ES segment, 0 = DS segment
mem_addr  out  16  offset
mem_wdata  out  8  write byte
mem_ack  in  1  request accepted; mem_rdata is valid in the ack cycle
mem_rdata  in  8  read byte

Behaviour:
- Reset (synchronous, checked before ce): state IDLE; busy=0, done=0, mem_req=0, mem_wr=0, mem_seg_es=0, mem_addr=0, mem_wdata=0, flags_out=0, internal cy=0, zacc=1.
- Reset during an operation aborts immediately. Any pending mem_req drops the next edge and no further write is issued.
- Byte count n = (count+1)>>1, computed on 9 bits. count=255 gives n=128.
- Start sequence: start accepted in IDLE only; ignored while busy. On accept, latch op, n, src_addr, dst_addr, flags_in; set cy=0, zacc=1, i=0.
- Per byte i, states are RD_SRC -> RD_DST -> ARITH -> ADJUST -> WR_DST -> NEXT:
  - RD_SRC: read byte at DS:(src+i).
  - RD_DST: read byte at ES:(dst+i).
  - ARITH: ALU op is ADDC for ADD4S, SUBC for SUB4S/CMP4S. ta = dst byte, tb = src byte, wide=0, flags_in.CY = cy. Latch the result byte and the ALU's AC and CY.
  - ADJUST: ALU op is ADJ4A for ADD4S, ADJ4S otherwise. ta = latched result; flags_in.AC/CY = latched values. Latch the adjusted byte. cy <= ALU CY. zacc <= zacc & (adjusted byte == 0).
  - WR_DST: write the adjusted byte to ES:(dst+i). Skipped for CMP4S, which goes straight to NEXT.
  - NEXT: i+1; return to RD_SRC if i+1 < n, else DONE.
- Offset arithmetic is modulo 2^16 (0xFFFF+1 wraps to 0x0000).
- Memory handshake: mem_req, mem_wr, mem_seg_es, mem_addr and mem_wdata are held stable from assertion until the cycle mem_ack=1 inclusive.
  - mem_req is deasserted on the edge after ack.
  - Ack may arrive in the first request cycle; wait states are unbounded.
- n=0: IDLE -> DONE directly; no memory access; CY=0, Z=1.
- DONE (one cycle): done=1, flags_out = latched flags with CY=cy and Z=zacc; all other flag bits are passed through. Then IDLE. busy drops in the cycle after done.
- ce=0: state and all outputs hold; mem_ack is sampled only when ce=1.

Optional Feature:
- Macro: BCD_SEQ_TIMING_EN.
- Defined: a wait counter pads execution so that the done pulse occurs exactly SETUP_CYCLES + n*BYTE_CYCLES ce-cycles after start, when memory acks arrive immediately. Extra memory wait cycles add on top; padding never shortens execution.
- Undefined: no padding; done follows the natural state sequence.

Decomposition:
- Shared types package gets:
  - enum bcd_op_e
  - enum bcd_seq_state_e
  - the reset default flags_t constant
- One sub-module: an instance of the core's alu, private to this block.
- The timing padding counter stays inline.

Test Plan:
- ADD4S, count=4, src bytes 34,12, dst bytes 66,98, immediate ack -> dst written 00,11; CY=1, Z=0; exactly 4 reads + 2 writes.
- SUB4S, count=4, src 01,00, dst 00,10 -> dst written 99,09; CY=0, Z=0.
- CMP4S, count=2, src 25, dst 25 -> no write cycles; CY=0, Z=1; other flag bits equal flags_in.
- count=0 -> done one cycle after start, mem_req never asserted, CY=0, Z=1.
- Wrap and odd count: src_addr=FFFF, count=3, 3-cycle ack delay on every access -> second read at DS:0000; address/data stable across the waits.
- Abort and busy: reset asserted during the second byte's RD_DST -> mem_req=0 and busy=0 next cycle, no write issued; a start pulse while busy is ignored.

Source files
------------

// File: rtl/bcd_string_seq_pkg.sv
// Shared types for the packed-BCD string sequencer and its private ALU.
package bcd_string_seq_pkg;

  typedef enum logic [1:0] {
    BcdAdd4s = 2'd0,
    BcdSub4s = 2'd1,
    BcdCmp4s = 2'd2
  } bcd_op_e;

  typedef enum logic [3:0] {
    StIdle,
    StRdSrc,
    StRdDst,
    StArith,
    StAdjust,
    StWrDst,
    StNext,
    StPad,
    StDone
  } bcd_seq_state_e;

  typedef enum logic [1:0] {
    AluAddc  = 2'd0,
    AluSubc  = 2'd1,
    AluAdj4a = 2'd2,
    AluAdj4s = 2'd3
  } alu_op_e;

  // PSW layout, MSB first; CY is bit 0, Z is bit 6.
  typedef struct packed {
    logic       md;
    logic [2:0] rsv_hi;
    logic       v;
    logic       dir;
    logic       ie;
    logic       brk;
    logic       s;
    logic       z;
    logic       rsv5;
    logic       ac;
    logic       rsv3;
    logic       p;
    logic       rsv1;
    logic       cy;
  } flags_t;

  localparam flags_t FlagsReset = '0;

  localparam int unsigned SetupCycles = 7;
  localparam int unsigned ByteCycles  = 19;

  function automatic flags_t merge_flags(flags_t f, logic cy, logic z);
    flags_t r = f;
    r.cy = cy;
    r.z  = z;
    return r;
  endfunction

endpackage

// File: rtl/bcd_string_seq_alu.sv
// Byte ALU slice: carry add/subtract and the decimal adjust passes.
module bcd_string_seq_alu
  import bcd_string_seq_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic [7:0] ta_i,
  input  logic [7:0] tb_i,
  input  logic       cy_i,
  input  logic       ac_i,
  output logic [7:0] res_o,
  output logic       cy_o,
  output logic       ac_o
);

  logic [8:0] wide;
  logic [4:0] nib;
  logic       lo_fix;
  logic       hi_fix;
  logic [7:0] fix;

  always_comb begin
    wide   = '0;
    nib    = '0;
    lo_fix = 1'b0;
    hi_fix = 1'b0;
    fix    = '0;
    res_o  = ta_i;
    cy_o   = 1'b0;
    ac_o   = 1'b0;
    unique case (alu_op_e'(op_i))
      AluAddc: begin
        wide  = {1'b0, ta_i} + {1'b0, tb_i} + {8'd0, cy_i};
        nib   = {1'b0, ta_i[3:0]} + {1'b0, tb_i[3:0]} + {4'd0, cy_i};
        res_o = wide[7:0];
        cy_o  = wide[8];
        ac_o  = nib[4];
      end
      AluSubc: begin
        wide  = {1'b0, ta_i} - {1'b0, tb_i} - {8'd0, cy_i};
        nib   = {1'b0, ta_i[3:0]} - {1'b0, tb_i[3:0]} - {4'd0, cy_i};
        res_o = wide[7:0];
        cy_o  = wide[8];
        ac_o  = nib[4];
      end
      AluAdj4a, AluAdj4s: begin
        // Both corrections are decided from the unadjusted byte.
        lo_fix = (ta_i[3:0] > 4'd9) || ac_i;
        hi_fix = (ta_i > 8'h99) || cy_i;
        fix    = {(hi_fix ? 4'h6 : 4'h0), (lo_fix ? 4'h6 : 4'h0)};
        res_o  = (alu_op_e'(op_i) == AluAdj4a) ? ta_i + fix : ta_i - fix;
        cy_o   = hi_fix;
        ac_o   = lo_fix;
      end
    endcase
  end

endmodule

// File: rtl/bcd_string_seq.sv
// ADD4S/SUB4S/CMP4S packed-BCD string sequencer beside the execute unit.
// Define BCD_SEQ_TIMING_EN to pad completion to the fixed per-byte cycle budget.
module bcd_string_seq
  import bcd_string_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [7:0]  count_i,
  input  logic [15:0] src_addr_i,
  input  logic [15:0] dst_addr_i,
  input  logic [15:0] flags_in_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] flags_out_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic        mem_seg_es_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i
);

  bcd_seq_state_e state_q, state_d;
  bcd_op_e        op_q, op_d;
  logic [7:0]     n_q, n_d, i_q, i_d;
  logic [15:0]    src_q, src_d, dst_q, dst_d;
  flags_t         flags_q, flags_d, flags_out_q, flags_out_d;
  logic           cy_q, cy_d, zacc_q, zacc_d;
  logic [7:0]     sbyte_q, sbyte_d, dbyte_q, dbyte_d;
  logic [7:0]     res_q, res_d, adj_q, adj_d;
  logic           ac_q, ac_d, acy_q, acy_d;
  logic           req_q, req_d, wr_q, wr_d, seg_q, seg_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;

  logic [8:0]     n_sum;
  logic [7:0]     n_start;
  logic           accept;

  logic [1:0]     alu_op;
  logic [7:0]     alu_ta, alu_res;
  logic           alu_cy_in, alu_ac_in, alu_cy, alu_ac;

  // Nine-bit sum so count=255 rounds up to 128 bytes.
  assign n_sum   = {1'b0, count_i} + 9'd1;
  assign n_start = n_sum[8:1];
  assign accept  = (state_q == StIdle) && start_i;

  bcd_string_seq_alu u_alu (
    .op_i (alu_op),
    .ta_i (alu_ta),
    .tb_i (sbyte_q),
    .cy_i (alu_cy_in),
    .ac_i (alu_ac_in),
    .res_o(alu_res),
    .cy_o (alu_cy),
    .ac_o (alu_ac)
  );

  always_comb begin
    alu_op    = AluAddc;
    alu_ta    = dbyte_q;
    alu_cy_in = cy_q;
    alu_ac_in = 1'b0;
    if (state_q == StAdjust) begin
      alu_op    = (op_q == BcdAdd4s) ? AluAdj4a : AluAdj4s;
      alu_ta    = res_q;
      alu_cy_in = acy_q;
      alu_ac_in = ac_q;
    end else if (op_q != BcdAdd4s) begin
      alu_op = AluSubc;
    end
  end

`ifdef BCD_SEQ_TIMING_EN
  logic [15:0] elapsed_q, target_q;
  logic        pad_met;

  assign pad_met = (elapsed_q >= target_q - 16'd1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      elapsed_q <= '0;
      target_q  <= '0;
    end else if (ce_i) begin
      if (accept) begin
        elapsed_q <= 16'd1;
        target_q  <= 16'(SetupCycles) + 16'(n_start) * 16'(ByteCycles);
      end else if (state_q != StIdle && elapsed_q != '1) begin
        elapsed_q <= elapsed_q + 16'd1;
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    n_d         = n_q;
    i_d         = i_q;
    src_d       = src_q;
    dst_d       = dst_q;
    flags_d     = flags_q;
    cy_d        = cy_q;
    zacc_d      = zacc_q;
    sbyte_d     = sbyte_q;
    dbyte_d     = dbyte_q;
    res_d       = res_q;
    adj_d       = adj_q;
    ac_d        = ac_q;
    acy_d       = acy_q;
    req_d       = req_q;
    wr_d        = wr_q;
    seg_d       = seg_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    flags_out_d = flags_out_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d    = bcd_op_e'(op_i);
          n_d     = n_start;
          i_d     = '0;
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          flags_d = flags_t'(flags_in_i);
          cy_d    = 1'b0;
          zacc_d  = 1'b1;
          if (n_start == 8'd0) begin
`ifdef BCD_SEQ_TIMING_EN
            state_d = StPad;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StRdSrc;
          end
        end
      end
      // Each access issues on its first cycle and retires on ack, so mem_req
      // always drops for at least one cycle between transfers.
      StRdSrc: begin
        if (!req_q) begin
          req_d  = 1'b1;
          wr_d   = 1'b0;
          seg_d  = 1'b0;
          addr_d = src_q + {8'd0, i_q};
        end else if (mem_ack_i) begin
          req_d   = 1'b0;
          sbyte_d = mem_rdata_i;
          state_d = StRdDst;
        end
      end
      StRdDst: begin
        if (!req_q) begin
          req_d  = 1'b1;
          wr_d   = 1'b0;
          seg_d  = 1'b1;
          addr_d = dst_q + {8'd0, i_q};
        end else if (mem_ack_i) begin
          req_d   = 1'b0;
          dbyte_d = mem_rdata_i;
          state_d = StArith;
        end
      end
      StArith: begin
        res_d   = alu_res;
        ac_d    = alu_ac;
        acy_d   = alu_cy;
        state_d = StAdjust;
      end
      StAdjust: begin
        adj_d   = alu_res;
        cy_d    = alu_cy;
        zacc_d  = zacc_q & (alu_res == 8'd0);
        state_d = (op_q == BcdCmp4s) ? StNext : StWrDst;
      end
      StWrDst: begin
        if (!req_q) begin
          req_d   = 1'b1;
          wr_d    = 1'b1;
          seg_d   = 1'b1;
          addr_d  = dst_q + {8'd0, i_q};
          wdata_d = adj_q;
        end else if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = StNext;
        end
      end
      StNext: begin
        i_d = i_q + 8'd1;
        if ((i_q + 8'd1) < n_q) begin
          state_d = StRdSrc;
        end else begin
`ifdef BCD_SEQ_TIMING_EN
          state_d = pad_met ? StDone : StPad;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef BCD_SEQ_TIMING_EN
      StPad: begin
        if (pad_met) state_d = StDone;
      end
`endif
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StDone && state_q != StDone) begin
      flags_out_d = merge_flags(flags_d, cy_d, zacc_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      op_q        <= BcdAdd4s;
      n_q         <= '0;
      i_q         <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      flags_q     <= FlagsReset;
      cy_q        <= 1'b0;
      zacc_q      <= 1'b1;
      sbyte_q     <= '0;
      dbyte_q     <= '0;
      res_q       <= '0;
      adj_q       <= '0;
      ac_q        <= 1'b0;
      acy_q       <= 1'b0;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      seg_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      flags_out_q <= FlagsReset;
    end else if (ce_i) begin
      state_q     <= state_d;
      op_q        <= op_d;
      n_q         <= n_d;
      i_q         <= i_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      flags_q     <= flags_d;
      cy_q        <= cy_d;
      zacc_q      <= zacc_d;
      sbyte_q     <= sbyte_d;
      dbyte_q     <= dbyte_d;
      res_q       <= res_d;
      adj_q       <= adj_d;
      ac_q        <= ac_d;
      acy_q       <= acy_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      seg_q       <= seg_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      flags_out_q <= flags_out_d;
    end
  end

  // The start term makes busy visible in the request cycle itself.
  assign busy_o       = (state_q != StIdle) || (start_i && ce_i && !reset_i);
  assign done_o       = (state_q == StDone);
  assign flags_out_o  = flags_out_q;
  assign mem_req_o    = req_q;
  assign mem_wr_o     = wr_q;
  assign mem_seg_es_o = seg_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;

endmodule

// File: tb/tb_bcd_string_seq.sv
// Scoreboard bench for bcd_string_seq: byte-wide memory model with configurable ack delay.
module tb_bcd_string_seq;
  import bcd_string_seq_pkg::*;

  typedef struct packed {
    logic        seg;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, ce, start;
  logic [1:0]  op;
  logic [7:0]  count;
  logic [15:0] src_addr, dst_addr, flags_in;
  logic        busy, done;
  logic [15:0] flags_out;
  logic        mem_req, mem_wr, mem_seg_es;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;

  int total_cnt = 0;
  int pass_cnt  = 0;

  wr_t         exp_wr_q[$];
  logic [16:0] rd_log[$];
  logic [7:0]  ds_mem[0:65535];
  logic [7:0]  es_mem[0:65535];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          rd_cnt    = 0;
  int          wr_cnt    = 0;
  int          done_cnt  = 0;
  logic        in_req    = 1'b0;
  logic        stable_err = 1'b0;
  logic        req_seen  = 1'b0;
  logic [25:0] first_req = '0;

  always #5 clk = ~clk;

  bcd_string_seq dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .ce_i        (ce),
    .start_i     (start),
    .op_i        (op),
    .count_i     (count),
    .src_addr_i  (src_addr),
    .dst_addr_i  (dst_addr),
    .flags_in_i  (flags_in),
    .busy_o      (busy),
    .done_o      (done),
    .flags_out_o (flags_out),
    .mem_req_o   (mem_req),
    .mem_wr_o    (mem_wr),
    .mem_seg_es_o(mem_seg_es),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  // Memory responder; writes are popped from the scoreboard as they retire.
  always @(negedge clk) begin
    wr_t e;
    mem_ack = 1'b0;
    if (mem_req) req_seen = 1'b1;
    if (mem_req && ce) begin
      if (!in_req) begin
        in_req    = 1'b1;
        wait_cnt  = 0;
        first_req = {mem_wr, mem_seg_es, mem_addr, mem_wdata};
      end else if ({mem_wr, mem_seg_es, mem_addr, mem_wdata} !== first_req) begin
        stable_err = 1'b1;
      end
      if (wait_cnt == ack_delay) begin
        mem_ack = 1'b1;
        in_req  = 1'b0;
        if (mem_wr) begin
          wr_cnt++;
          if (mem_seg_es) es_mem[mem_addr] = mem_wdata;
          else ds_mem[mem_addr] = mem_wdata;
          total_cnt++;
          if (exp_wr_q.size() == 0) begin
            $display("FAIL unexpected_write got %b:%h=%h want none",
                     mem_seg_es, mem_addr, mem_wdata);
          end else begin
            e = exp_wr_q.pop_front();
            if ({mem_seg_es, mem_addr, mem_wdata} !== e)
              $display("FAIL write_data got %b:%h=%h want %b:%h=%h",
                       mem_seg_es, mem_addr, mem_wdata, e.seg, e.addr, e.data);
            else pass_cnt++;
          end
        end else begin
          rd_cnt++;
          rd_log.push_back({mem_seg_es, mem_addr});
          mem_rdata = mem_seg_es ? es_mem[mem_addr] : ds_mem[mem_addr];
        end
      end else begin
        wait_cnt++;
      end
    end else if (!mem_req) begin
      in_req = 1'b0;
    end
  end

  always @(posedge clk) if (ce && done && !reset) done_cnt++;

  function automatic logic [15:0] exp_flags(input logic [15:0] f, input logic cy, input logic z);
    return (f & 16'hFFBE) | {15'd0, cy} | {9'd0, z, 6'd0};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0;
    wr_cnt = 0;
    rd_log.delete();
    stable_err = 1'b0;
    req_seen = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [7:0] c, input logic [15:0] s,
                        input logic [15:0] d, input logic [15:0] f,
                        output int lat, output logic [15:0] fo, output logic timed_out);
    op = o; count = c; src_addr = s; dst_addr = d; flags_in = f;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      tick(1);
      lat++;
    end
    timed_out = !done;
    fo = flags_out;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b0; start = 1'b0;
    tick(2);
    total_cnt++;
    if ({busy, done, mem_req, mem_wr, mem_seg_es} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {busy, done, mem_req, mem_wr, mem_seg_es});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_wdata, flags_out} !== 40'd0)
      $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, flags_out});
    else pass_cnt++;
    reset = 1'b0; ce = 1'b1;
    tick(2);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_add();
    int lat; logic [15:0] fo; logic to;
    ds_mem[16'h1000] = 8'h34; ds_mem[16'h1001] = 8'h12;
    es_mem[16'h2000] = 8'h66; es_mem[16'h2001] = 8'h98;
    ack_delay = 0; clear_stats();
    exp_wr_q.push_back({1'b1, 16'h2000, 8'h00});
    exp_wr_q.push_back({1'b1, 16'h2001, 8'h11});
    run_op(BcdAdd4s, 8'd4, 16'h1000, 16'h2000, 16'h0A45, lat, fo, to);
    total_cnt++;
    if (to || fo !== exp_flags(16'h0A45, 1'b1, 1'b0))
      $display("FAIL add_flags got %h (timeout %b) want %h", fo, to,
               exp_flags(16'h0A45, 1'b1, 1'b0));
    else pass_cnt++;
    total_cnt++;
    if (rd_cnt != 4 || wr_cnt != 2 || exp_wr_q.size() != 0)
      $display("FAIL add_access got rd=%0d wr=%0d left=%0d want 4/2/0",
               rd_cnt, wr_cnt, exp_wr_q.size());
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL add_after_done got %b want 00", {busy, done});
    else pass_cnt++;
  endtask

  task automatic test_sub();
    int lat; logic [15:0] fo; logic to;
    ds_mem[16'h1100] = 8'h01; ds_mem[16'h1101] = 8'h00;
    es_mem[16'h2100] = 8'h00; es_mem[16'h2101] = 8'h10;
    ack_delay = 0; clear_stats();
    exp_wr_q.push_back({1'b1, 16'h2100, 8'h99});
    exp_wr_q.push_back({1'b1, 16'h2101, 8'h09});
    run_op(BcdSub4s, 8'd4, 16'h1100, 16'h2100, 16'h8041, lat, fo, to);
    total_cnt++;
    if (to || fo !== exp_flags(16'h8041, 1'b0, 1'b0))
      $display("FAIL sub_flags got %h (timeout %b) want %h", fo, to,
               exp_flags(16'h8041, 1'b0, 1'b0));
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt != 2 || exp_wr_q.size() != 0)
      $display("FAIL sub_writes got wr=%0d left=%0d want 2/0", wr_cnt, exp_wr_q.size());
    else pass_cnt++;
    tick(1);
  endtask

  task automatic test_cmp();
    int lat; logic [15:0] fo; logic to;
    ds_mem[16'h1200] = 8'h25; es_mem[16'h2200] = 8'h25;
    ack_delay = 0; clear_stats();
    run_op(BcdCmp4s, 8'd2, 16'h1200, 16'h2200, 16'h0895, lat, fo, to);
    total_cnt++;
    if (to || fo !== exp_flags(16'h0895, 1'b0, 1'b1))
      $display("FAIL cmp_flags got %h (timeout %b) want %h", fo, to,
               exp_flags(16'h0895, 1'b0, 1'b1));
    else pass_cnt++;
    total_cnt++;
    if (rd_cnt != 2 || wr_cnt != 0)
      $display("FAIL cmp_access got rd=%0d wr=%0d want 2/0", rd_cnt, wr_cnt);
    else pass_cnt++;
    tick(1);
  endtask

  task automatic test_zero_count();
    int lat; logic [15:0] fo; logic to;
    ack_delay = 0; clear_stats();
    run_op(BcdAdd4s, 8'd0, 16'h1000, 16'h2000, 16'h0011, lat, fo, to);
    total_cnt++;
    if (to || lat != 1) $display("FAIL zero_latency got %0d want 1", lat);
    else pass_cnt++;
    total_cnt++;
    if (fo !== exp_flags(16'h0011, 1'b0, 1'b1) || req_seen)
      $display("FAIL zero_flags got %h req_seen=%b want %h req_seen=0", fo, req_seen,
               exp_flags(16'h0011, 1'b0, 1'b1));
    else pass_cnt++;
    tick(1);
  endtask

  task automatic test_wrap_odd();
    int lat; logic [15:0] fo; logic to;
    ds_mem[16'hFFFF] = 8'h11; ds_mem[16'h0000] = 8'h05;
    es_mem[16'h0100] = 8'h22; es_mem[16'h0101] = 8'h04;
    ack_delay = 3; clear_stats();
    exp_wr_q.push_back({1'b1, 16'h0100, 8'h33});
    exp_wr_q.push_back({1'b1, 16'h0101, 8'h09});
    run_op(BcdAdd4s, 8'd3, 16'hFFFF, 16'h0100, 16'h0000, lat, fo, to);
    total_cnt++;
    if (to || fo !== exp_flags(16'h0000, 1'b0, 1'b0))
      $display("FAIL wrap_flags got %h (timeout %b) want %h", fo, to,
               exp_flags(16'h0000, 1'b0, 1'b0));
    else pass_cnt++;
    total_cnt++;
    if (rd_log.size() != 4 || rd_log[0] !== {1'b0, 16'hFFFF} || rd_log[2] !== {1'b0, 16'h0000})
      $display("FAIL wrap_addr got n=%0d r2=%h want n=4 r2=00000", rd_log.size(), rd_log[2]);
    else pass_cnt++;
    total_cnt++;
    if (stable_err !== 1'b0 || exp_wr_q.size() != 0)
      $display("FAIL wrap_stable got err=%b left=%0d want 0/0", stable_err, exp_wr_q.size());
    else pass_cnt++;
    tick(1);
  endtask

  task automatic test_ce_hold();
    logic [18:0] snap;
    int lat;
    ds_mem[16'h1300] = 8'h50; ds_mem[16'h1301] = 8'h20;
    es_mem[16'h2300] = 8'h50; es_mem[16'h2301] = 8'h30;
    ack_delay = 2; clear_stats();
    op = BcdCmp4s; count = 8'd4; src_addr = 16'h1300; dst_addr = 16'h2300;
    flags_in = 16'h0001;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    snap = {busy, mem_req, mem_seg_es, mem_addr};
    ce = 1'b0;
    tick(6);
    total_cnt++;
    if ({busy, mem_req, mem_seg_es, mem_addr} !== snap || done)
      $display("FAIL ce_hold got %h done=%b want %h done=0",
               {busy, mem_req, mem_seg_es, mem_addr}, done, snap);
    else pass_cnt++;
    ce = 1'b1;
    lat = 0;
    while (!done && lat < 3000) begin
      tick(1);
      lat++;
    end
    total_cnt++;
    if (!done || flags_out !== exp_flags(16'h0001, 1'b0, 1'b0) || rd_cnt != 4)
      $display("FAIL ce_result got %h rd=%0d done=%b want %h rd=4 done=1", flags_out, rd_cnt,
               done, exp_flags(16'h0001, 1'b0, 1'b0));
    else pass_cnt++;
    tick(1);
  endtask

  task automatic test_busy_ignore();
    int lat, d0;
    ds_mem[16'h1400] = 8'h45; es_mem[16'h2400] = 8'h44;
    ack_delay = 0; clear_stats();
    exp_wr_q.push_back({1'b1, 16'h2400, 8'h89});
    d0 = done_cnt;
    op = BcdAdd4s; count = 8'd2; src_addr = 16'h1400; dst_addr = 16'h2400;
    flags_in = 16'h0000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_mid got %b want 1", busy);
    else pass_cnt++;
    op = BcdSub4s; count = 8'd0; src_addr = 16'h7000; dst_addr = 16'h7100;
    flags_in = 16'hFFFF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 3000) begin
      tick(1);
      lat++;
    end
    total_cnt++;
    if (!done || flags_out !== exp_flags(16'h0000, 1'b0, 1'b0))
      $display("FAIL busy_flags got %h done=%b want %h", flags_out, done,
               exp_flags(16'h0000, 1'b0, 1'b0));
    else pass_cnt++;
    tick(5);
    total_cnt++;
    if (done_cnt - d0 != 1 || wr_cnt != 1 || exp_wr_q.size() != 0 || busy)
      $display("FAIL busy_ignore got dones=%0d wr=%0d busy=%b want 1/1/0",
               done_cnt - d0, wr_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_max_count();
    int lat; logic [15:0] fo; logic to;
    for (int k = 0; k < 128; k++) begin
      ds_mem[16'h4000 + 16'(k)] = 8'h00;
      es_mem[16'h5000 + 16'(k)] = 8'h00;
    end
    ack_delay = 0; clear_stats();
    run_op(BcdCmp4s, 8'd255, 16'h4000, 16'h5000, 16'h0001, lat, fo, to);
    total_cnt++;
    if (to || rd_cnt != 256 || fo !== exp_flags(16'h0001, 1'b0, 1'b1))
      $display("FAIL max_count got rd=%0d flags=%h want 256 %h", rd_cnt, fo,
               exp_flags(16'h0001, 1'b0, 1'b1));
    else pass_cnt++;
    tick(1);
  endtask

  task automatic test_abort();
    int lat;
    ds_mem[16'h1500] = 8'h11; ds_mem[16'h1501] = 8'h22;
    es_mem[16'h2500] = 8'h33; es_mem[16'h2501] = 8'h44;
    ack_delay = 3; clear_stats();
    exp_wr_q.push_back({1'b1, 16'h2500, 8'h44});
    op = BcdAdd4s; count = 8'd4; src_addr = 16'h1500; dst_addr = 16'h2500;
    flags_in = 16'h0000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    lat = 0;
    while (!(mem_req && mem_seg_es && !mem_wr && mem_addr == 16'h2501) && lat < 300) begin
      tick(1);
      lat++;
    end
    total_cnt++;
    if (lat >= 300) $display("FAIL abort_reach got timeout want second RD_DST");
    else pass_cnt++;
    reset = 1'b1;
    tick(1);
    total_cnt++;
    if ({mem_req, busy, done} !== 3'b000)
      $display("FAIL abort_drop got %b want 000", {mem_req, busy, done});
    else pass_cnt++;
    reset = 1'b0;
    req_seen = 1'b0;
    tick(20);
    total_cnt++;
    if (wr_cnt != 1 || exp_wr_q.size() != 0 || req_seen || busy)
      $display("FAIL abort_quiet got wr=%0d left=%0d req=%b busy=%b want 1/0/0/0",
               wr_cnt, exp_wr_q.size(), req_seen, busy);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; start = 1'b0; op = 2'd0; count = 8'd0;
    src_addr = 16'd0; dst_addr = 16'd0; flags_in = 16'd0;
    for (int k = 0; k < 65536; k++) begin
      ds_mem[k] = 8'h00;
      es_mem[k] = 8'h00;
    end
    tick(1);
    test_reset();
    test_add();
    test_sub();
    test_cmp();
    test_zero_count();
    test_wrap_odd();
    test_ce_hold();
    test_busy_ignore();
    test_max_count();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog");
  end

endmodule
